// File: rtl/cpc_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpc_ram_pkg
// Brief   : Shared constants, FSM state type and page-map helper for the
//           CPC RAM-expansion bank controller.
// Revision: 1.0 - initial release
// ============================================================================
package cpc_ram_pkg;

  // Memory configuration values written to D[2:0] of the gate-array port
  localparam logic [2:0] CFG_0 = 3'd0;
  localparam logic [2:0] CFG_1 = 3'd1;
  localparam logic [2:0] CFG_2 = 3'd2;
  localparam logic [2:0] CFG_3 = 3'd3;
  localparam logic [2:0] CFG_4 = 3'd4;
  localparam logic [2:0] CFG_5 = 3'd5;
  localparam logic [2:0] CFG_6 = 3'd6;
  localparam logic [2:0] CFG_7 = 3'd7;

  // D[7:6] value that selects the memory-configuration function of &7Fxx
  localparam logic [1:0] PORT_GA_SEL = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_t;

  typedef struct packed {
    logic       mapped;
    logic [1:0] ext_page;
  } page_map_t;

  // Map a CPU 16K page onto an expansion page for the given configuration.
  // The internal-RAM remap half of cfg3 is handled by the main board, so
  // only its page-3 redirection matters here.
  function automatic page_map_t page_map(input logic [2:0] cfg,
                                         input logic [1:0] page);
    page_map_t r;
    r.mapped   = 1'b0;
    r.ext_page = 2'd0;
    case (cfg)
      CFG_1, CFG_3: begin
        if (page == 2'd3) begin
          r.mapped   = 1'b1;
          r.ext_page = 2'd3;
        end
      end
      CFG_2: begin
        r.mapped   = 1'b1;
        r.ext_page = page;
      end
      CFG_4, CFG_5, CFG_6, CFG_7: begin
        if (page == 2'd1) begin
          r.mapped   = 1'b1;
          r.ext_page = cfg[1:0];
        end
      end
      default: begin
        r.mapped   = 1'b0;
        r.ext_page = 2'd0;
      end
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpc_io_wr_detect.sv
`default_nettype none
// ============================================================================
// Module  : cpc_io_wr_detect
// Brief   : Turns a (possibly wait-stated) Z80 I/O write to the gate-array
//           port into a single-cycle load strobe.
// Revision: 1.0 - initial release
// ============================================================================
module cpc_io_wr_detect
  import cpc_ram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic port_wr,       // decoded write to the &7Fxx port
  input  logic io_wr_active,  // IOREQ_B and WR_B both still low
  output logic load
);

  fsm_t state_q;
  fsm_t state_d;

  // State register; reset returns to IDLE even in the middle of a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and load strobe: load only on the IDLE->BUSY edge
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (port_wr) begin
          state_d = BUSY;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (!io_wr_active) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpc_ram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpc_ram_bank_ctrl
// Brief   : CPC RAM-expansion controller. Snoops the gate-array memory
//           configuration port, holds bank/config and decodes each memory
//           access into RAMDIS and expansion SRAM controls.
// Revision: 1.0 - initial release
// ============================================================================
module cpc_ram_bank_ctrl
  import cpc_ram_pkg::*;
#(
  parameter int unsigned NUM_BANKS_LOG2 = 3
) (
  input  logic                      CLK,
  input  logic                      RESET_B,
  input  logic [1:0]                A_HI,
  input  logic [7:0]                D,
  input  logic                      IOREQ_B,
  input  logic                      MREQ_B,
  input  logic                      RD_B,
  input  logic                      WR_B,
  input  logic                      M1_B,
  input  logic                      RFSH_B,
  input  logic                      RAMRD_B,
  output logic                      RAMDIS,
  output logic                      RAM_CE_B,
  output logic                      RAM_OE_B,
  output logic                      RAM_WE_B,
  output logic [NUM_BANKS_LOG2+1:0] RAM_ADR_HI,
  output logic [5:0]                CFG
);

  // Bank bits above the fitted RAM are dropped so larger bank numbers alias
  localparam logic [2:0] C_BANK_MASK = 3'((1 << NUM_BANKS_LOG2) - 1);

  logic [2:0] bank_q, bank_d;
  logic [2:0] cfg_q, cfg_d;
  logic       w_port_wr;
  logic       w_io_wr_active;
  logic       w_load;
  page_map_t  w_map;
  logic       w_ext_sel;

  // M1_B high excludes interrupt-acknowledge; A14 is not decoded
  assign w_io_wr_active = !IOREQ_B && !WR_B;
  assign w_port_wr      = w_io_wr_active && M1_B && !A_HI[1];

  cpc_io_wr_detect u_io_wr_detect (
    .clk          (CLK),
    .rst_n        (RESET_B),
    .port_wr      (w_port_wr),
    .io_wr_active (w_io_wr_active),
    .load         (w_load)
  );

  // Bank/config register; pen, mode and ROM writes pass through untouched
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      bank_q <= 3'd0;
      cfg_q  <= 3'd0;
    end else begin
      bank_q <= bank_d;
      cfg_q  <= cfg_d;
    end
  end

  // Load new bank/config only on the strobe of a memory-config write
  always_comb begin
    bank_d = bank_q;
    cfg_d  = cfg_q;
    if (w_load && (D[7:6] == PORT_GA_SEL)) begin
      bank_d = D[5:3] & C_BANK_MASK;
      cfg_d  = D[2:0];
    end
  end

  // Access decode from registered config and the live bus
  always_comb begin
    w_map     = page_map(cfg_q, A_HI);
    w_ext_sel = w_map.mapped && !MREQ_B && RFSH_B &&
                ((!RD_B && !RAMRD_B) || !WR_B);
    RAMDIS    = w_ext_sel;
    RAM_CE_B  = !w_ext_sel;
    RAM_OE_B  = !(w_ext_sel && !RD_B);
    RAM_WE_B  = !(w_ext_sel && !WR_B);
    if (w_map.mapped) begin
      RAM_ADR_HI = {bank_q[NUM_BANKS_LOG2-1:0], w_map.ext_page};
    end else begin
      RAM_ADR_HI = '0;
    end
  end

  assign CFG = {bank_q, cfg_q};

endmodule
`default_nettype wire

// File: tb/tb_cpc_ram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpc_ram_bank_ctrl
// Brief   : Self-checking bench for cpc_ram_bank_ctrl with a behavioural
//           model; two instances cover 8-bank and 2-bank builds.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpc_ram_bank_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_B = 1'b0;
  logic [1:0] A_HI = 2'd0;
  logic [7:0] D = 8'd0;
  logic       IOREQ_B = 1'b1, MREQ_B = 1'b1, RD_B = 1'b1, WR_B = 1'b1;
  logic       M1_B = 1'b1, RFSH_B = 1'b1, RAMRD_B = 1'b1;

  logic       ramdis3, ce3, oe3, we3;
  logic [4:0] adr3;
  logic [5:0] cfg3;
  logic       ramdis1, ce1, oe1, we1;
  logic [2:0] adr1;
  logic [5:0] cfg1;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b1;

  cpc_ram_bank_ctrl #(.NUM_BANKS_LOG2(3)) u_dut3 (
    .CLK(CLK), .RESET_B(RESET_B), .A_HI(A_HI), .D(D), .IOREQ_B(IOREQ_B),
    .MREQ_B(MREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B),
    .RAMRD_B(RAMRD_B), .RAMDIS(ramdis3), .RAM_CE_B(ce3), .RAM_OE_B(oe3),
    .RAM_WE_B(we3), .RAM_ADR_HI(adr3), .CFG(cfg3)
  );

  cpc_ram_bank_ctrl #(.NUM_BANKS_LOG2(1)) u_dut1 (
    .CLK(CLK), .RESET_B(RESET_B), .A_HI(A_HI), .D(D), .IOREQ_B(IOREQ_B),
    .MREQ_B(MREQ_B), .RD_B(RD_B), .WR_B(WR_B), .M1_B(M1_B), .RFSH_B(RFSH_B),
    .RAMRD_B(RAMRD_B), .RAMDIS(ramdis1), .RAM_CE_B(ce1), .RAM_OE_B(oe1),
    .RAM_WE_B(we1), .RAM_ADR_HI(adr1), .CFG(cfg1)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // m_bank keeps the full D[5:3]; each build masks it to its own width.
  logic [2:0] m_bank = 3'd0;
  logic [2:0] m_cfg = 3'd0;
  bit         m_in_out = 1'b0;   // inside an I/O write that already counted
  logic       m_io_w;
  assign m_io_w = !IOREQ_B && !WR_B;

  // One load per OUT: the first edge of an I/O write to &7Fxx with A15=0
  always @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      m_bank   <= 3'd0;
      m_cfg    <= 3'd0;
      m_in_out <= 1'b0;
    end else if (!m_in_out) begin
      if (m_io_w && M1_B && !A_HI[1]) begin
        m_in_out <= 1'b1;
        if (D[7:6] == 2'b11) begin
          m_bank <= D[5:3];
          m_cfg  <= D[2:0];
        end
      end
    end else if (!m_io_w) begin
      m_in_out <= 1'b0;
    end
  end

  // Expansion page a CPU page lands on, or -1 for internal RAM
  function automatic int ext_of(input int c, input int p);
    if (c == 1 || c == 3) return (p == 3) ? 3 : -1;
    if (c == 2) return p;
    if (c >= 4) return (p == 1) ? c - 4 : -1;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    int  e, b3, b1;
    bit  mapped, sel;
    e      = ext_of(int'(m_cfg), int'(A_HI));
    mapped = (e >= 0);
    sel    = mapped && !MREQ_B && RFSH_B && ((!RD_B && !RAMRD_B) || !WR_B);
    b3     = int'(m_bank) % 8;
    b1     = int'(m_bank) % 2;
    check("ramdis3", 32'(ramdis3), 32'(sel));
    check("ce3", 32'(ce3), 32'(!sel));
    check("oe3", 32'(oe3), 32'(!(sel && !RD_B)));
    check("we3", 32'(we3), 32'(!(sel && !WR_B)));
    check("adr3", 32'(adr3), mapped ? 32'(b3 * 4 + e) : 32'd0);
    check("cfg3", 32'(cfg3), 32'(b3 * 8 + int'(m_cfg)));
    check("ramdis1", 32'(ramdis1), 32'(sel));
    check("ce1", 32'(ce1), 32'(!sel));
    check("oe1", 32'(oe1), 32'(!(sel && !RD_B)));
    check("we1", 32'(we1), 32'(!(sel && !WR_B)));
    check("adr1", 32'(adr1), mapped ? 32'(b1 * 4 + e) : 32'd0);
    check("cfg1", 32'(cfg1), 32'(b1 * 8 + int'(m_cfg)));
  endtask

  // Continuous comparison against the model, away from the rising edge
  always @(negedge CLK) begin
    if (cmp_en) cmp_all();
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus(input logic [1:0] a, input logic [7:0] d,
                     input logic ioreq, input logic mreq, input logic rd,
                     input logic wr, input logic m1, input logic rfsh,
                     input logic ramrd);
    @(posedge CLK);
    #2;
    A_HI = a; D = d; IOREQ_B = ioreq; MREQ_B = mreq; RD_B = rd; WR_B = wr;
    M1_B = m1; RFSH_B = rfsh; RAMRD_B = ramrd;
  endtask

  task automatic idle();
    bus(2'd0, 8'h00, 1, 1, 1, 1, 1, 1, 1);
  endtask

  task automatic io_out(input logic [1:0] a, input logic [7:0] d, input int n);
    bus(a, d, 0, 1, 1, 0, 1, 1, 1);
    repeat (n - 1) @(posedge CLK);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier");
    $fatal(1);
  end

  initial begin
    logic [1:0] a;
    logic [7:0] d;
    logic       ioreq, mreq, rd, wr, m1, rfsh, ramrd;
    int         kind;

    repeat (3) @(posedge CLK);
    #2 RESET_B = 1'b1;
    @(negedge CLK);
    check("rst_cfg", 32'(cfg3), 32'd0);
    check("rst_ramdis", 32'(ramdis3), 32'd0);
    check("rst_ce", 32'(ce3), 32'd1);
    check("rst_adr", 32'(adr3), 32'd0);

    // read &C000 with cfg0 stays internal
    bus(2'd3, 8'h00, 1, 0, 0, 1, 1, 1, 0);
    @(negedge CLK);
    check("c000_rd_internal", 32'(ramdis3), 32'd0);

    // OUT &7F00,&C1 held 3 clocks, then data changes while still held
    bus(2'd1, 8'hC1, 0, 1, 1, 0, 1, 1, 1);
    repeat (2) @(posedge CLK);
    bus(2'd1, 8'hC2, 0, 1, 1, 0, 1, 1, 1);
    idle();
    @(negedge CLK);
    check("one_load_cfg1", 32'(cfg3), 32'h01);

    bus(2'd3, 8'h00, 1, 0, 1, 0, 1, 1, 1);   // write &C123
    @(negedge CLK);
    check("c123_wr_ramdis", 32'(ramdis3), 32'd1);
    check("c123_wr_we", 32'(we3), 32'd0);
    check("c123_wr_adr", 32'(adr3), 32'h03);
    bus(2'd1, 8'h00, 1, 0, 1, 0, 1, 1, 1);   // write &4000
    @(negedge CLK);
    check("4000_wr_ramdis", 32'(ramdis3), 32'd0);
    idle();

    // OUT &7F00,&EE: bank5 cfg6
    io_out(2'd1, 8'hEE, 1);
    @(negedge CLK);
    check("ee_cfg3", 32'(cfg3), 32'h2E);
    check("ee_cfg1", 32'(cfg1), 32'h0E);
    bus(2'd1, 8'h00, 1, 0, 0, 1, 1, 1, 0);   // read &5000 RAMRD_B=0
    @(negedge CLK);
    check("5000_rd_oe", 32'(oe3), 32'd0);
    check("5000_rd_adr3", 32'(adr3), 32'h16);
    check("5000_rd_adr1", 32'(adr1), 32'h6);
    bus(2'd1, 8'h00, 1, 0, 0, 1, 1, 1, 1);   // same read, ROM-sourced
    @(negedge CLK);
    check("5000_rom_rd_ramdis", 32'(ramdis3), 32'd0);
    idle();

    // non-config writes leave the register alone
    io_out(2'd1, 8'h8C, 1);
    io_out(2'd2, 8'hC2, 2);
    bus(2'd1, 8'hC2, 0, 1, 1, 0, 0, 1, 1);   // interrupt acknowledge
    idle();
    @(negedge CLK);
    check("no_load_cfg", 32'(cfg3), 32'h2E);

    // cfg2, then a refresh cycle must not select
    io_out(2'd1, 8'hC2, 1);
    bus(2'd0, 8'h00, 1, 0, 0, 1, 1, 0, 0);
    @(negedge CLK);
    check("rfsh_ce", 32'(ce3), 32'd1);

    // reset in the middle of a held OUT
    bus(2'd1, 8'hC5, 0, 1, 1, 0, 1, 1, 1);
    @(posedge CLK);
    #2 RESET_B = 1'b0;
    #1;
    check("async_rst_cfg3", 32'(cfg3), 32'd0);
    check("async_rst_cfg1", 32'(cfg1), 32'd0);
    idle();
    RESET_B = 1'b1;
    io_out(2'd1, 8'hC4, 1);
    @(negedge CLK);
    check("post_rst_cfg4", 32'(cfg3), 32'h04);

    // bank7 cfg4: the 2-bank build aliases to bank 1
    io_out(2'd1, 8'hFC, 1);
    bus(2'd1, 8'h00, 1, 0, 0, 1, 1, 1, 0);
    @(negedge CLK);
    check("fc_cfg1", 32'(cfg1), 32'h0C);
    check("fc_adr1", 32'(adr1), 32'h4);
    check("fc_adr3", 32'(adr3), 32'h1C);
    idle();

    // randomized bus traffic checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      kind = $urandom_range(0, 9);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      ioreq = 1; mreq = 1; rd = 1; wr = 1; m1 = 1; rfsh = 1;
      ramrd = 1'($urandom);
      case (kind)
        1, 2, 3: begin
          ioreq = 0; wr = 0;
          if ($urandom_range(0, 1) == 1) d[7:6] = 2'b11;
          if ($urandom_range(0, 2) != 0) a[1] = 1'b0;
        end
        4: begin ioreq = 0; m1 = 0; wr = 1'($urandom); d[7:6] = 2'b11; end
        5, 6: begin mreq = 0; rd = 0; end
        7: begin mreq = 0; wr = 0; end
        8: begin mreq = 0; rfsh = 0; rd = 1'($urandom); wr = 1'($urandom); end
        9: begin
          ioreq = 1'($urandom); mreq = 1'($urandom); rd = 1'($urandom);
          wr = 1'($urandom); m1 = 1'($urandom); rfsh = 1'($urandom);
        end
        default: ;
      endcase
      bus(a, d, ioreq, mreq, rd, wr, m1, rfsh, ramrd);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
    idle();
    @(negedge CLK);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpc_ram_bank_ctrl.md
Name: cpc_ram_bank_ctrl

Overview:
- RAM-expansion controller for a card plugged into a socket on the CPC bus backplane. It consumes the Z80/gate-array bus signals that the backplane distributes.
- Snoops I/O writes to the memory-configuration port (&7Fxx, data[7:6]=11) and holds a 6-bit bank/config register.
- For each memory access, decodes whether the expansion RAM must respond. Drives RAMDIS back onto the bus and generates the SRAM chip controls and upper address bits.

Parameters:
- NUM_BANKS_LOG2, 3, log2 of the number of 64K expansion banks (legal 1..3). Bank field = D[3+NUM_BANKS_LOG2-1:3]; higher bank bits are ignored, so banks alias.

Ports:
- CLK  in  1  CPC bus clock (4 MHz); all state changes on its rising edge.
- RESET_B  in  1  asynchronous active-low reset (CPC bus RESET_B).
- A_HI  in  2  {A15,A14}.
- D  in  8  bus data, sampled only.
- IOREQ_B  in  1  Z80 I/O request.
- MREQ_B  in  1  Z80 memory request.
- RD_B  in  1  Z80 read strobe.
- WR_B  in  1  Z80 write strobe.
- M1_B  in  1  Z80 M1.
- RFSH_B  in  1  Z80 refresh.
- RAMRD_B  in  1  gate-array RAM-read enable (low when a read is not ROM-sourced).
- RAMDIS  out  1  high disables internal RAM for the current access.
- RAM_CE_B  out  1  expansion SRAM chip enable.
- RAM_OE_B  out  1  expansion SRAM output enable.
- RAM_WE_B  out  1  expansion SRAM write enable.
- RAM_ADR_HI  out  NUM_BANKS_LOG2+2  {bank, ext_page}; SRAM address above A13.
- CFG  out  6  current {bank[2:0], cfg[2:0]}, for debug/LED header.

Behaviour:
- Reset (RESET_B low, async): bank=0, cfg=0, FSM=IDLE. Outputs: RAMDIS=0, RAM_CE_B=1, RAM_OE_B=1, RAM_WE_B=1, RAM_ADR_HI=0, CFG=0. Release is synchronous to the CLK edge.
- port_wr = !IOREQ_B & !WR_B & M1_B & !A15. A14 is don't-care. Interrupt-acknowledge (M1_B low with IOREQ_B low) is never a port write.
- I/O write FSM, sampled on rising CLK:
  - IDLE: if port_wr, go to BUSY. On that same edge, if D[7:6]==2'b11, load bank=D[5:3] (masked to NUM_BANKS_LOG2 bits, upper bits 0) and cfg=D[2:0]. If D[7:6]!=11 (pen/mode/ROM writes), go to BUSY but leave the register unchanged.
  - BUSY: stay while !IOREQ_B & !WR_B; go to IDLE when either strobe deasserts.
  - Result: exactly one load per I/O cycle regardless of wait states. Back-to-back OUTs each load.
- New config is visible on CFG and in the decode from the latching edge onward, i.e. 0 CLK latency after the edge and effective for the next M-cycle.
- Page mapping, page = A_HI; map gives ext_page or none:
  - cfg0: none.
  - cfg1: p3 -> e3.
  - cfg2: p0..p3 -> e0..e3.
  - cfg3: p3 -> e3; p1 stays internal (the internal-remap portion of cfg3 is out of scope for this card).
  - cfg4..7: p1 -> e(cfg-4).
- ext_sel = mapped & !MREQ_B & RFSH_B & ((!RD_B & !RAMRD_B) | !WR_B).
- Outputs, combinational from the registered config and live bus:
  - RAMDIS = ext_sel.
  - RAM_CE_B = !ext_sel.
  - RAM_OE_B = !(ext_sel & !RD_B).
  - RAM_WE_B = !(ext_sel & !WR_B).
  - RAM_ADR_HI = {bank, ext_page} when mapped, else 0.
- Boundary conditions:
  - Refresh cycles (MREQ_B low, RFSH_B low): never select.
  - ROM-sourced reads (RAMRD_B high): not selected. Writes to ROM-overlaid addresses still go to the expansion RAM when mapped.
  - A simultaneous IOREQ_B and MREQ_B is not a legal Z80 state; the decode is still evaluated independently.
  - Reset asserted mid-BUSY: the FSM returns to IDLE immediately and the register clears.

Decomposition:
- Package cpc_ram_pkg holds:
  - CFG_* constants (0..7).
  - PORT_GA_SEL = 2'b11 (data[7:6] match).
  - The fsm_t enum {IDLE, BUSY}.
  - The page-map function (cfg, page) -> {mapped, ext_page}.
- Sub-module cpc_io_wr_detect: the FSM, producing a one-cycle load strobe. The top level holds the register and the decode.

Test Plan:
- Reset then idle bus -> CFG=0, RAMDIS=0, RAM_CE_B=1, RAM_ADR_HI=0; reads at &C000 hit internal RAM.
- OUT &7F00,&C1 held 3 CLKs -> exactly one load, CFG=6'b000_001. Write to &C123 -> RAMDIS=1, RAM_WE_B=0, RAM_ADR_HI={0,2'b11}. Access to &4000 -> RAMDIS=0.
- OUT &7F00,&EE (bank5, cfg6) with NUM_BANKS_LOG2=3 -> read &5000 with RAMRD_B=0 gives RAM_OE_B=0, RAM_ADR_HI={3'b101,2'b10}. Same read with RAMRD_B=1 -> RAMDIS=0.
- OUT &7F00,&8C (D[7:6]=10) and OUT &BC00,&C2 (A15=1) -> CFG unchanged. Interrupt-acknowledge with D=&C2 on the bus -> CFG unchanged.
- cfg2 active, refresh cycle at &0000 (MREQ_B=0, RFSH_B=0) -> RAM_CE_B=1. Then RESET_B pulsed low mid-BUSY -> CFG=0 asynchronously, FSM IDLE, next OUT &7F00,&C4 loads cfg4.
- NUM_BANKS_LOG2=1, OUT &7F00,&FC (bank7, cfg4) -> bank=1, access &4000 -> RAM_ADR_HI={1'b1,2'b00}.
